// File: rtl/compmul_pipe_if.sv
// ---------------------------------------------------------------------------
// compmul_pipe_if
//   Handshake and data bundle for the pipelined complex multiplier.
//   master : upstream/downstream environment (drives operands and i_ready)
//   slave  : the multiplier itself (drives o_ready and the result)
//   Signals:
//     i_valid, o_ready        input-side valid/ready handshake
//     i_conj_b                1 = multiply by conj(b), sampled with i_valid
//     i_a_re/im, i_b_re/im    signed operands
//     o_valid, i_ready        output-side valid/ready handshake
//     o_res_re/im, o_ovf      signed result and out-of-range flag
// ---------------------------------------------------------------------------
interface compmul_pipe_if #(
  parameter int DATA_WIDTH = 16
);
  logic                         i_valid;
  logic                         o_ready;
  logic                         i_conj_b;
  logic signed [DATA_WIDTH-1:0] i_a_re;
  logic signed [DATA_WIDTH-1:0] i_a_im;
  logic signed [DATA_WIDTH-1:0] i_b_re;
  logic signed [DATA_WIDTH-1:0] i_b_im;
  logic                         o_valid;
  logic                         i_ready;
  logic signed [DATA_WIDTH-1:0] o_res_re;
  logic signed [DATA_WIDTH-1:0] o_res_im;
  logic                         o_ovf;

  modport master (
    output i_valid, i_conj_b, i_a_re, i_a_im, i_b_re, i_b_im, i_ready,
    input  o_ready, o_valid, o_res_re, o_res_im, o_ovf
  );

  modport slave (
    input  i_valid, i_conj_b, i_a_re, i_a_im, i_b_re, i_b_im, i_ready,
    output o_ready, o_valid, o_res_re, o_res_im, o_ovf
  );
endinterface

// File: rtl/compmul_pipe.sv
// ---------------------------------------------------------------------------
// compmul_pipe
//   Three-stage pipelined complex multiplier, res = a*b or a*conj(b), on
//   signed Q(INT_WIDTH).(FRAC_WIDTH) operands, using the 3-multiplier Gauss
//   form. Optional round-half-up and saturation, per-sample overflow flag,
//   valid/ready handshake with a global stall on backpressure.
//   Ports:
//     i_clk  rising-edge clock
//     i_rst  synchronous active-high reset
//     bus    compmul_pipe_if.slave (handshake, operands, result, o_ovf)
// ---------------------------------------------------------------------------
module compmul_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 12,
  parameter int INT_WIDTH  = 4,
  parameter bit ROUND_EN   = 1'b1,
  parameter bit SAT_EN     = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  compmul_pipe_if.slave bus
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * W + 1;  // product width
  localparam int FW = 2 * W + 2;  // combined (full) width
  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  // Whole pipeline moves together; it stalls only when a result is waiting
  // and downstream refuses it.
  logic advance;
  assign advance     = !bus.o_valid || bus.i_ready;
  assign bus.o_ready = advance;

  // ---------------- stage 1: capture, optional conjugate ----------------
  logic signed [W-1:0] b_im_eff;
  logic                s1_valid;
  logic signed [W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im;

  // Negating the most negative value is not representable; clamp it.
  always_comb begin
    b_im_eff = bus.i_b_im;
    if (bus.i_conj_b)
      b_im_eff = (bus.i_b_im == MIN_V) ? MAX_V : -bus.i_b_im;
  end

  // ---------------- stage 2: three real products ----------------
  logic signed [W:0]    a_diff, b_diff, b_sum;
  logic signed [PW-1:0] z_n, p_n, q_n;
  logic                 s2_valid;
  logic signed [PW-1:0] s2_z, s2_p, s2_q;

  assign a_diff = {s1_a_re[W-1], s1_a_re} - {s1_a_im[W-1], s1_a_im};
  assign b_diff = {s1_b_re[W-1], s1_b_re} - {s1_b_im[W-1], s1_b_im};
  assign b_sum  = {s1_b_re[W-1], s1_b_re} + {s1_b_im[W-1], s1_b_im};

  // re = p + z = a_re*b_re - a_im*b_im ; im = q - z = a_re*b_im + a_im*b_re
  assign z_n = PW'(s1_b_re) * PW'(a_diff);
  assign p_n = PW'(s1_a_im) * PW'(b_diff);
  assign q_n = PW'(s1_a_re) * PW'(b_sum);

  // ---------------- stage 3: combine, round, range-limit ----------------
  logic signed [FW-1:0] full_re, full_im;
  logic [W:0]           re_sc, im_sc;  // {ovf, result}

  assign full_re = FW'(s2_p) + FW'(s2_z);
  assign full_im = FW'(s2_q) - FW'(s2_z);

  function automatic logic [W:0] scale(input logic signed [FW-1:0] full);
    logic signed [FW-1:0] rnd;
    logic signed [FW-1:0] sh;
    logic                 ovf;
    logic [W-1:0]         res;
    rnd = full;
    if (ROUND_EN) rnd = full + FW'(2 ** (FRAC_WIDTH - 1));
    sh  = rnd >>> FRAC_WIDTH;
    ovf = (sh > FW'(MAX_V)) || (sh < FW'(MIN_V));
    res = sh[W-1:0];  // wrap: keep the low bits
    if (SAT_EN && ovf) res = sh[FW-1] ? MIN_V : MAX_V;
    return {ovf, res};
  endfunction

  assign re_sc = scale(full_re);
  assign im_sc = scale(full_im);

  // NOTE: datapath registers carry no reset; their contents are don't-care
  // whenever the matching valid bit is low, so only control state is reset.
  always_ff @(posedge i_clk) begin
    if (advance) begin
      s1_a_re <= bus.i_a_re;
      s1_a_im <= bus.i_a_im;
      s1_b_re <= bus.i_b_re;
      s1_b_im <= b_im_eff;
      s2_z    <= z_n;
      s2_p    <= p_n;
      s2_q    <= q_n;
    end
  end

  // Valid chain and output register. The result only loads for a real
  // sample, so it holds its last value across bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      bus.o_valid  <= 1'b0;
      bus.o_res_re <= '0;
      bus.o_res_im <= '0;
      bus.o_ovf    <= 1'b0;
    end else if (advance) begin
      s1_valid    <= bus.i_valid;
      s2_valid    <= s1_valid;
      bus.o_valid <= s2_valid;
      if (s2_valid) begin
        bus.o_res_re <= re_sc[W-1:0];
        bus.o_res_im <= im_sc[W-1:0];
        bus.o_ovf    <= re_sc[W] | im_sc[W];
      end
    end
  end

  // INT_WIDTH only documents the format; DATA_WIDTH is authoritative.
  logic unused_int_width;
  assign unused_int_width = (INT_WIDTH + FRAC_WIDTH) == DATA_WIDTH;

endmodule

// File: doc/compmul_pipe.md
Name: compmul_pipe

Overview:
- Pipelined, parametrised complex multiplier for the FFT/IFFT datapath and channel-equalisation paths of the NB-IoT uplink PHY.
- Computes res = a * b, or res = a * conj(b) per sample, on signed fixed-point Q(INT_WIDTH).(FRAC_WIDTH) operands.
- Uses 3 real multipliers (Gauss form), 3 register stages, selectable rounding and saturation, an overflow flag, and a valid/ready handshake with backpressure.

Parameters:
- DATA_WIDTH, 16, operand/result width; must equal INT_WIDTH+FRAC_WIDTH.
- FRAC_WIDTH, 12, fractional bits of operands and result.
- INT_WIDTH, 4, integer bits including sign.
- ROUND_EN, 1, 1 = round half up (add 2^(FRAC_WIDTH-1) before the shift); 0 = truncate toward -inf.
- SAT_EN, 1, 1 = clamp out-of-range results to the signed max/min; 0 = wrap (keep the low DATA_WIDTH bits).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  block can accept an input this cycle.
- i_conj_b  in  1  1 = use conj(b); sampled with i_valid.
- i_a_re, i_a_im  in  DATA_WIDTH  operand a, signed.
- i_b_re, i_b_im  in  DATA_WIDTH  operand b, signed.
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accepts the output.
- o_res_re, o_res_im  out  DATA_WIDTH  result, signed.
- o_ovf  out  1  result of this sample exceeded range (re or im); qualified by o_valid.

Behaviour:
- Reset: synchronous, active-high (i_rst sampled on i_clk rising edge). Clears all stage valid bits, o_valid, o_res_re, o_res_im and o_ovf to 0. o_ready is 1 in the first cycle after reset deasserts. Reset mid-operation discards every in-flight sample; no output appears for them.
- Handshake:
  - Input transfer when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - advance = !o_valid || i_ready; o_ready = advance (combinational).
  - When advance = 0, all three stages hold data and valid bits unchanged (global stall).
  - Bubbles are not collapsed. Order is always preserved; no sample is lost or duplicated.
- Latency: 3 cycles from the input transfer to o_valid with no stall. Throughput: 1 sample/cycle.
- Stage 1 (register):
  - Capture a, b and the conj flag.
  - If conj, b_im' = -b_im. The special case -2^(DATA_WIDTH-1) maps to 2^(DATA_WIDTH-1)-1 (saturate), independent of SAT_EN.
- Stage 2 (multiply): compute and register
  - z = b_re*(a_re-a_im)
  - p = a_im*(b_re-b_im')
  - q = a_re*(b_re+b_im')
  - Differences and sums are DATA_WIDTH+1 bits; products are 2*DATA_WIDTH+1 bits, with no intermediate truncation.
- Stage 3 (combine and scale):
  - full_re = p + z; full_im = q - z, each 2*DATA_WIDTH+2 bits.
  - If ROUND_EN, add 2^(FRAC_WIDTH-1); then arithmetic shift right by FRAC_WIDTH.
  - Range check against [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. o_ovf = out-of-range on re OR im.
  - If SAT_EN, clamp to max/min; else output the low DATA_WIDTH bits.
- Outputs are registered and stable while o_valid && !i_ready.
- Data registers are don't-care when their stage valid bit is 0. o_res holds its last value when o_valid = 0.

Test Plan:
- Basic, Q4.12: a = (4096, 0) [1.0], b = (2048, 2048), conj = 0 -> 3 cycles later o_res = (2048, 2048), o_ovf = 0.
- Conjugate: a = b = (4096, 4096), conj = 1 -> o_res = (8192, 0). Same inputs with conj = 0 -> (0, 8192).
- Saturation/overflow: a = b = (32767, 0) -> full/2^12 = 262128. With SAT_EN = 1: o_res_re = 32767, o_ovf = 1. With SAT_EN = 0: o_res_re = 262128 mod 2^16 as signed = -16, o_ovf = 1. Also b_im = -32768, conj = 1, a = (4096, 0) -> o_res_im = 32767.
- Rounding: a = (1, 0), b = (2048, 0) -> ROUND_EN = 1 gives o_res_re = 1; ROUND_EN = 0 gives 0. a = (-1, 0), same b -> ROUND_EN = 1 gives 0; ROUND_EN = 0 gives -1.
- Backpressure: 5 back-to-back inputs (values 1..5 × 4096 times b = (4096, 0)), i_ready low for cycles 4-6 -> o_ready low for exactly those cycles; outputs 4096..20480 in order, each presented until accepted, none lost.
- Reset mid-stream: 3 samples in flight, pulse i_rst for 1 cycle -> o_valid = 0 and outputs = 0 the next cycle; none of the 3 samples emerges; a new sample gives a correct result 3 cycles after acceptance.
